bus_timer: RTL and testbench

- Memory-mapped countdown timer that acts as a bus responder on the maxicore32 external bus.
- It answers the CPU's word-aligned read/write cycles (address[31:2], data, data_strobes, read, write) behind an external address decoder.
- It provides a prescaled 32-bit down-counter with reload, an expiry flag and an interrupt request.
- It is the target-side counterpart of the core's bus initiator.

---
 rtl/bus_timer.sv | 82 ++++++++
 tb/tb_bus_timer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/bus_timer.sv
// bus_timer: memory-mapped prescaled down-counter with reload, expiry flag and irq (optional IRQ via BUS_TIMER_IRQ_EN)
module bus_timer #(
  parameter int          PRESCALE_WIDTH = 16,
  parameter logic [31:0] RESET_RELOAD   = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        select,
  input  logic [1:0]  address,
  input  logic [31:0] data_in,
  input  logic [3:0]  data_strobes,
  input  logic        read,
  input  logic        write,
  output logic [31:0] data_out,
  output logic        irq
);
  logic                      enable, auto_reload, irq_en, expired;
  logic [PRESCALE_WIDTH-1:0] prescale, pcnt;
  logic [31:0]               reload, count;
  logic                      wr_en, wr_ctrl, wr_ps, wr_rl, wr_cnt, tick, expire, clear;
  logic [31:0]               ps_merged, rl_merged, cnt_merged, ctrl_val, rd_val;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i+:8] = n[8*i+:8];
    return r;
  endfunction

  // decode bus writes, prescaler tick and expiry, and the read mux
  always_comb begin
    wr_en      = select & write & |data_strobes;
    wr_ctrl    = wr_en & (address == 2'd0);
    wr_ps      = wr_en & (address == 2'd1);
    wr_rl      = wr_en & (address == 2'd2);
    wr_cnt     = wr_en & (address == 2'd3);
    clear      = wr_ctrl & data_strobes[1] & data_in[8];
    tick       = enable & (pcnt == '0);
    expire     = tick & (count == 32'd0) & ~wr_cnt;
    ps_merged  = merge(32'(prescale), data_in, data_strobes);
    rl_merged  = merge(reload, data_in, data_strobes);
    cnt_merged = merge(count, data_in, data_strobes);
    ctrl_val   = {23'd0, expired, 5'd0, irq_en, auto_reload, enable};
    rd_val     = address == 2'd0 ? ctrl_val :
                 address == 2'd1 ? 32'(prescale) :
                 address == 2'd2 ? reload : count;
    data_out   = (select & read) ? rd_val : 32'h0;
  end

  // register file, prescaler and counter; one-shot auto-clear overrides a same-cycle ENABLE write
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      enable      <= 1'b0;
      auto_reload <= 1'b0;
      expired     <= 1'b0;
      prescale    <= '0;
      pcnt        <= '0;
      reload      <= RESET_RELOAD;
      count       <= 32'd0;
    end else begin
      enable      <= (expire & ~auto_reload) ? 1'b0 : (wr_ctrl & data_strobes[0]) ? data_in[0] : enable;
      auto_reload <= (wr_ctrl & data_strobes[0]) ? data_in[1] : auto_reload;
      expired     <= expire | (expired & ~clear);
      prescale    <= wr_ps ? ps_merged[PRESCALE_WIDTH-1:0] : prescale;
      reload      <= wr_rl ? rl_merged : reload;
      count       <= wr_cnt ? cnt_merged :
                     tick ? (count != 32'd0 ? count - 32'd1 : auto_reload ? reload : count) : count;
      pcnt        <= wr_cnt ? prescale :
                     enable ? (pcnt == '0 ? prescale : pcnt - PRESCALE_WIDTH'(1)) : pcnt;
    end

`ifdef BUS_TIMER_IRQ_EN
  // interrupt enable bit; irq follows the registered flag with no extra delay
  always_ff @(posedge clock or posedge reset)
    if (reset) irq_en <= 1'b0;
    else irq_en <= (wr_ctrl & data_strobes[0]) ? data_in[2] : irq_en;
  assign irq = expired & irq_en;
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif
endmodule

// File: tb/tb_bus_timer.sv
// tb_bus_timer: randomized and directed checks of bus_timer against a behavioural model
module tb_bus_timer;
  localparam int PW = 16;
`ifdef BUS_TIMER_IRQ_EN
  localparam bit IRQ_IMPL = 1'b1;
`else
  localparam bit IRQ_IMPL = 1'b0;
`endif
  logic        clock = 0, reset = 1, select = 0, read = 0, write = 0, irq;
  logic [1:0]  address = 0;
  logic [31:0] data_in = 0, data_out, got;
  logic [3:0]  data_strobes = 0;
  int          n_checks = 0, n_pass = 0;
  bit          m_en, m_ar, m_ie, m_exp;
  logic [31:0] m_ps, m_rl, m_cnt, m_pc;

  bus_timer #(.PRESCALE_WIDTH(PW), .RESET_RELOAD(32'h0)) dut (
    .clock(clock), .reset(reset), .select(select), .address(address), .data_in(data_in),
    .data_strobes(data_strobes), .read(read), .write(write), .data_out(data_out), .irq(irq));

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
  endtask

  function automatic logic [31:0] bytes_merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r = o;
    for (int i = 0; i < 4; i++)
      if (s[i]) r = (r & ~(32'hFF << (8 * i))) | (n & (32'hFF << (8 * i)));
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0: return (m_exp ? 32'h100 : 0) | (m_ie ? 32'h4 : 0) | (m_ar ? 32'h2 : 0) | (m_en ? 32'h1 : 0);
      2'd1: return m_ps;
      2'd2: return m_rl;
      default: return m_cnt;
    endcase
  endfunction

  task automatic m_reset();
    m_en = 0; m_ar = 0; m_ie = 0; m_exp = 0; m_ps = 0; m_rl = 0; m_cnt = 0; m_pc = 0;
  endtask

  // one clock of the timer as the register-level rules describe it
  task automatic m_step(input bit sel, input logic [1:0] a, input logic [31:0] d, input logic [3:0] s, input bit wr);
    bit w, cw, tick, expire, clr, old_ar;
    logic [31:0] n_pc, n_cnt;
    w = sel && wr && s != 0;
    cw = w && a == 3;
    tick = m_en && m_pc == 0;
    expire = tick && m_cnt == 0 && !cw;
    old_ar = m_ar;
    n_pc = cw ? m_ps : !m_en ? m_pc : m_pc == 0 ? m_ps : m_pc - 1;
    n_cnt = cw ? bytes_merge(m_cnt, d, s) : !tick ? m_cnt : m_cnt != 0 ? m_cnt - 1 : old_ar ? m_rl : 0;
    clr = 0;
    if (w && a == 0) begin
      if (s[0]) begin m_en = d[0]; m_ar = d[1]; m_ie = IRQ_IMPL && d[2]; end
      clr = s[1] && d[8];
    end
    if (w && a == 1) m_ps = bytes_merge(m_ps, d, s) % (64'd1 << PW);
    if (w && a == 2) m_rl = bytes_merge(m_rl, d, s);
    m_exp = expire || (m_exp && !clr);
    if (expire && !old_ar) m_en = 0;
    m_pc = n_pc; m_cnt = n_cnt;
  endtask

  task automatic bus(input bit sel, input logic [1:0] a, input logic [31:0] d, input logic [3:0] s,
                     input bit rd, input bit wr, output logic [31:0] q);
    select = sel; address = a; data_in = d; data_strobes = s; read = rd; write = wr;
    @(negedge clock);
    q = data_out;
    check("rdata", data_out, (sel && rd) ? m_read(a) : 32'h0);
    check("irq", {31'd0, irq}, {31'd0, IRQ_IMPL && m_exp && m_ie});
    @(posedge clock);
    m_step(sel, a, d, s, wr);
    #1;
    select = 0; read = 0; write = 0;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] q;
    bus(1, a, d, s, 0, 1, q);
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [31:0] q);
    bus(1, a, 0, 0, 1, 0, q);
  endtask

  initial begin
    logic [31:0] q;
    m_reset();
    repeat (2) @(posedge clock);
    #1 reset = 0;
    rd_reg(0, q); check("rst_ctrl", q, 0);
    rd_reg(3, q); check("rst_cnt", q, 0);

    // one-shot with PRESCALE=0
    wr_reg(1, 0, 4'hF); wr_reg(3, 3, 4'hF); wr_reg(0, 32'h5, 4'hF);
    rd_reg(3, q); check("os_cnt3", q, 3);
    rd_reg(3, q); check("os_cnt2", q, 2);
    rd_reg(3, q); check("os_cnt1", q, 1);
    rd_reg(3, q); check("os_cnt0", q, 0);
    rd_reg(0, q); check("os_ctrl", q, IRQ_IMPL ? 32'h104 : 32'h100);
    check("os_irq", {31'd0, irq}, {31'd0, IRQ_IMPL});
    rd_reg(3, q); check("os_hold", q, 0);
    wr_reg(0, 32'h100, 4'h2);
    rd_reg(0, q); check("os_clr", q, IRQ_IMPL ? 32'h4 : 32'h0);

    // auto-reload with PRESCALE=2
    wr_reg(1, 2, 4'hF); wr_reg(2, 1, 4'hF); wr_reg(3, 1, 4'hF); wr_reg(0, 3, 4'h1);
    repeat (14) rd_reg(3, q);
    rd_reg(0, q); check("ar_ctrl", q, 32'h103);
    wr_reg(0, 32'h100, 4'h3);

    // partial-strobe COUNT write
    wr_reg(3, 32'hFFFF_FFFF, 4'hF); wr_reg(3, 32'h1234_5678, 4'b0011);
    rd_reg(3, q); check("strobe_cnt", q, 32'hFFFF_5678);

    // clear colliding with expiry: set wins
    wr_reg(1, 3, 4'hF); wr_reg(2, 0, 4'hF); wr_reg(3, 0, 4'hF); wr_reg(0, 7, 4'h1);
    repeat (3) rd_reg(2, q);
    wr_reg(0, 32'h100, 4'h2);
    rd_reg(0, q); check("coll_set", q, IRQ_IMPL ? 32'h107 : 32'h103);
    wr_reg(0, 32'h100, 4'h3);
    rd_reg(0, q); check("coll_clr", q, 0);
    check("coll_irq", {31'd0, irq}, 0);

    // unselected accesses
    wr_reg(2, 32'hCAFE, 4'hF);
    bus(0, 2, 0, 0, 1, 0, q); check("nosel_rd", q, 0);
    bus(0, 2, 32'h1111, 4'hF, 0, 1, q);
    rd_reg(2, q); check("nosel_wr", q, 32'hCAFE);

    // asynchronous reset mid-count
    wr_reg(1, 0, 4'hF); wr_reg(3, 5, 4'hF); wr_reg(0, 1, 4'h1);
    rd_reg(3, q);
    select = 1; read = 1; address = 3;
    #2 reset = 1;
    #1 check("arst_cnt", data_out, 0);
    m_reset();
    @(negedge clock); reset = 0;
    read = 0; select = 0;
    @(posedge clock); #1;
    repeat (3) rd_reg(3, q);
    check("arst_frozen", q, 0);
    rd_reg(0, q); check("arst_ctrl", q, 0);
    rd_reg(2, q); check("arst_rl", q, 0);

    // random traffic
    for (int k = 0; k < 800; k++) begin
      logic [1:0] a;
      logic [31:0] d;
      logic [3:0] s;
      bit sel, rd, wr;
      a = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 9) != 0;
      rd = $urandom_range(0, 1) == 1;
      wr = $urandom_range(0, 3) == 0;
      s = $urandom_range(0, 2) == 0 ? 4'($urandom) : 4'hF;
      d = a == 1 ? $urandom_range(0, 3) : a == 3 ? $urandom_range(0, 12) :
          a == 2 ? $urandom_range(0, 8) : ($urandom & 32'h107) | ($urandom_range(0, 2) != 0 ? 32'h1 : 0);
      bus(sel, a, d, s, rd, wr, q);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
